// File: rtl/vga_sync_core.sv
// VGA sync core: pixel-clock divider, x/y raster counters, and a delay-matched
// sync/blanking path so that hsync, vsync and rgb leave the block aligned with
// a pixel source that needs PIPE_DLY clocks to answer for a given x/y.
//
// Pixel source contract: si_rgb is sampled on every clk with no handshake.
// The value present PIPE_DLY clks after x/y changes is taken as the pixel for
// that position. Pixels arriving outside the visible area are discarded.
module vga_sync_core #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] si_rgb,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        p_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_LAST     = 11'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT      = 11'(H_DISPLAY);
  localparam logic [10:0] HS_START   = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] V_ACT      = 11'(V_DISPLAY);
  localparam logic [10:0] VS_START   = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_DISPLAY + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [10:0]      r_x;
  logic [10:0]      r_y;
  logic             w_tick;
  logic             w_x_wrap;
  logic [2:0]       w_raw;   // {h_sync_raw, v_sync_raw, video_on}
  logic [2:0]       w_dly;   // w_raw after PIPE_DLY clks
  logic             r_hsync;
  logic             r_vsync;
  logic [11:0]      r_rgb;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_x_wrap = w_tick && (r_x == H_LAST);

  // Pixel-clock divider: counts 0..CLK_DIV-1, restarting after the tick clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Horizontal counter: one step per pixel tick, wraps at the end of the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
    end else if (w_tick) begin
      r_x <= (r_x == H_LAST) ? 11'd0 : r_x + 11'd1;
    end
  end

  // Vertical counter: steps only on the tick that wraps x, wraps at frame end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y <= '0;
    end else if (w_x_wrap) begin
      r_y <= (r_y == V_LAST) ? 11'd0 : r_y + 11'd1;
    end
  end

  // Strobes are masked while reset is held so a reset counter state of zero
  // does not look like a tick or a frame start.
  assign x           = r_x;
  assign y           = r_y;
  assign p_tick      = reset_n & w_tick;
  assign frame_start = reset_n & (r_div == '0) & (r_x == 11'd0) & (r_y == 11'd0);

  // Raw timing decode straight from the counters.
  assign w_raw[2] = (r_x >= HS_START) && (r_x < HS_END);
  assign w_raw[1] = (r_y >= VS_START) && (r_y < VS_END);
  assign w_raw[0] = (r_x < H_ACT) && (r_y < V_ACT);

  generate
    if (PIPE_DLY > 0) begin : g_pipe
      logic [2:0] r_pipe [PIPE_DLY];

      // Alignment shift register matching the pixel source latency.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            r_pipe[i] <= '0;
          end
        end else begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_dly = r_pipe[PIPE_DLY-1];
    end else begin : g_bypass
      assign w_dly = w_raw;
    end
  endgenerate

  // Output register: sync polarity inversion and blanking of the pixel data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 12'h000;
    end else begin
      r_hsync <= ~w_dly[2];
      r_vsync <= ~w_dly[1];
      r_rgb   <= w_dly[0] ? si_rgb : 12'h000;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign rgb   = r_rgb;

endmodule

// File: doc/vga_sync_core.md
VGA_SYNC_CORE -- requirements
Module: vga_sync_core

Interface
REQ-001 Parameters (name, default, meaning):
- CLK_DIV, 4: system clocks per pixel.
- H_DISPLAY, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing, in pixels.
- V_DISPLAY, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing, in lines.
- PIPE_DLY, 2: latency in clk cycles of the pixel source driven by x/y.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- reset_n, in, 1: asynchronous active-low reset.
- si_rgb, in, 12: pixel from the source, {r,g,b} 4 bits each, valid PIPE_DLY clks after x/y.
- x, out, 11: current horizontal pixel count.
- y, out, 11: current vertical line count.
- p_tick, out, 1: one-clk pixel strobe.
- frame_start, out, 1: one-clk pulse at x=0, y=0.
- hsync, out, 1: active-low horizontal sync.
- vsync, out, 1: active-low vertical sync.
- rgb, out, 12: pixel to the DAC.

Function
REQ-003 Divider: mod-CLK_DIV counter, 0..CLK_DIV-1; p_tick=1 only in the clk where the counter is CLK_DIV-1.
REQ-004 Horizontal counter: x advances only on p_tick; range 0..HT-1, where HT=H_DISPLAY+H_FP+H_SYNC+H_BP (800); wraps HT-1 -> 0.
REQ-005 Vertical counter: y advances only on the p_tick where x wraps; range 0..VT-1, where VT=V_DISPLAY+V_FP+V_SYNC+V_BP (525); wraps VT-1 -> 0 on that same p_tick.
REQ-006 x and y are the registered counter values, driven directly with no added latency.
REQ-007 frame_start=1 for exactly one clk: the clk where x=0, y=0 and the divider is 0.
REQ-008 Raw timing signals, decoded combinationally from x and y:
- h_sync_raw=1 when H_DISPLAY+H_FP <= x < H_DISPLAY+H_FP+H_SYNC (656..751).
- v_sync_raw=1 when V_DISPLAY+V_FP <= y < V_DISPLAY+V_FP+V_SYNC (490..491).
- video_on=1 when x < H_DISPLAY and y < V_DISPLAY.
REQ-009 Alignment shift register: {h_sync_raw, v_sync_raw, video_on} passes through PIPE_DLY clk-stage registers, shifting every clk.
REQ-010 Output register stage, one clk after the alignment shift register:
- hsync = ~h_sync_dly; vsync = ~v_sync_dly.
- rgb = si_rgb when video_on_dly=1, else 12'h000.
REQ-011 Total latency from x/y change to the matching hsync/vsync/rgb change is PIPE_DLY+1 clks; it is identical for sync and pixel data.
REQ-012 si_rgb is sampled every clk; no handshake; a pixel not on a video_on_dly cycle is discarded.
REQ-013 Boundary at x=HT-1, y=VT-1 with p_tick: both counters wrap to 0 in the same clk; frame_start fires on the following divider-0 clk.
REQ-014 With PIPE_DLY=0 the alignment register is bypassed and latency is 1 clk.
REQ-015 All state is held in flip-flops; no latches; the block has no combinational path from si_rgb to any output.

Reset
REQ-016 reset_n=0 asynchronously clears the divider, x, y and all alignment registers to 0.
REQ-017 During reset: hsync=1, vsync=1, rgb=12'h000, p_tick=0, frame_start=0.
REQ-018 Reset asserted mid-line or mid-frame aborts the frame; no partial-state carryover.
REQ-019 After reset_n rises, the first p_tick occurs CLK_DIV clks later; frame_start fires in the first clk after release.
REQ-020 For PIPE_DLY+1 clks after release, hsync=1, vsync=1 and rgb=0, because the alignment registers are cleared.

Verification
REQ-021 Release reset, count clks between p_tick pulses -> every interval is 4 clks; x reaches 799 then returns to 0.
REQ-022 Run one full frame -> exactly 800*525*4 = 1,680,000 clks between frame_start pulses; y wraps 524 -> 0.
REQ-023 hsync measurement -> hsync low for 96*4 = 384 clks, falling edge PIPE_DLY+1 = 3 clks after x becomes 656; vsync low for exactly 2 lines, starting at y=490.
REQ-024 Drive si_rgb = {x[3:0], y[3:0], 4'hA} delayed 2 clks (model source) -> at x=5, y=7 the rgb output equals 12'h57A 3 clks after x=5 appears; rgb=000 for x>=640 and for y>=480.
REQ-025 Assert reset_n=0 at x=300, y=200, hold 5 clks, release -> x=y=0 during reset; hsync=vsync=1; rgb=0; frame_start pulses in the first clk after release; counting restarts.
REQ-026 Override parameters CLK_DIV=1, PIPE_DLY=0 -> p_tick constantly 1; rgb tracks si_rgb with 1-clk latency inside the active region.
